// File: rtl/dma_bus_arbiter.sv
// DMA bus arbiter for the 6809 system bus.
// Takes the bus from the cpu09 core with the HALT/BA/BS handshake, caps each DMA burst at
// MAX_BURST transfers and gives the CPU at least CPU_SLOT cycles between bursts. Halt
// requests the CPU never acknowledges are abandoned after GRANT_TIMEOUT cycles and flagged.
module dma_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned CPU_SLOT      = 4,
  parameter int unsigned GRANT_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_rw,
  input  logic [7:0]            cpu_dout,
  input  logic                  cpu_ba,
  input  logic                  cpu_bs,
  output logic                  cpu_halt,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic                  dma_rw,
  input  logic [7:0]            dma_wdata,
  output logic                  dma_grant,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_rw,
  output logic [7:0]            bus_wdata,
  output logic                  bus_owner,
  input  logic                  err_clear,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StHaltReq,
    StGranted,
    StRelease,
    StCooldown
  } state_e;

  // Terminal counts as 8-bit compare values; CPU_SLOT == 0 never reaches the slot compare.
  localparam int unsigned SlotLastInt = (CPU_SLOT == 0) ? 0 : CPU_SLOT - 1;
  localparam logic [7:0]  BurstLast   = 8'(MAX_BURST);
  localparam logic [7:0]  WaitLast    = 8'(GRANT_TIMEOUT - 1);
  localparam logic [7:0]  SlotLast    = 8'(SlotLastInt);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] burst_q, burst_d;
  logic [7:0] slot_q, slot_d;
  logic       cpu_halt_q, cpu_halt_d;
  logic       timeout_err_q, timeout_err_d;
  logic       timeout_set;
  logic       granted;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // State, counters, halt and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      wait_q        <= 8'd0;
      burst_q       <= 8'd0;
      slot_q        <= 8'd0;
      cpu_halt_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      burst_q       <= burst_d;
      slot_q        <= slot_d;
      cpu_halt_q    <= cpu_halt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    burst_d     = burst_q;
    slot_d      = slot_q;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dma_req) begin
          state_d = StHaltReq;
          wait_d  = 8'd0;
        end
      end
      StHaltReq: begin
        // dma_req is not looked at here; a dropped request is handled once granted.
        if (cpu_ba && cpu_bs) begin
          state_d = StGranted;
          burst_d = 8'd0;
        end else if (wait_q == WaitLast) begin
          timeout_set = 1'b1;
          state_d     = StRelease;
        end else begin
          wait_d = sat_inc(wait_q);
        end
      end
      StGranted: begin
        if (dma_req) begin
          burst_d = sat_inc(burst_q);
          if (sat_inc(burst_q) == BurstLast) begin
            state_d = StRelease;
          end
        end else begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        // Halt is already low; wait for the CPU to take the bus back.
        if (!cpu_ba) begin
          if (CPU_SLOT == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StCooldown;
            slot_d  = 8'd0;
          end
        end
      end
      StCooldown: begin
        // Requests are not latched here; the CPU keeps the bus for the whole slot.
        if (slot_q == SlotLast) begin
          state_d = StIdle;
        end else begin
          slot_d = sat_inc(slot_q);
        end
      end
      default: state_d = StIdle;
    endcase

    // A timeout in the same cycle as a clear leaves the flag set.
    if (timeout_set) begin
      timeout_err_d = 1'b1;
    end else if (err_clear) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // Outputs: registered halt, grant from current state, combinational bus mux.
  always_comb begin
    cpu_halt_d = (state_d == StHaltReq) || (state_d == StGranted);
    granted    = (state_q == StGranted);
    if (granted) begin
      bus_addr  = dma_addr;
      bus_rw    = dma_rw;
      bus_wdata = dma_wdata;
    end else begin
      bus_addr  = cpu_addr;
      bus_rw    = cpu_rw;
      bus_wdata = cpu_dout;
    end
  end

  assign dma_grant   = granted;
  assign bus_owner   = granted;
  assign cpu_halt    = cpu_halt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: directed handshake/timeout/reset checks plus a randomized
// scoreboard phase. The driver queues expected transfers and expected grant-run lengths;
// a negedge monitor pops and compares them as the DUT grants the bus.
module tb_dma_bus_arbiter;
  localparam int unsigned AW            = 16;
  localparam int unsigned MAX_BURST     = 16;
  localparam int unsigned CPU_SLOT      = 4;
  localparam int unsigned GRANT_TIMEOUT = 255;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          rw;
    logic [7:0]    d;
  } xfer_t;

  typedef struct {
    int len;
    bit more;
  } run_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] cpu_addr;
  logic          cpu_rw;
  logic [7:0]    cpu_dout;
  logic          cpu_ba;
  logic          cpu_bs;
  logic          cpu_halt;
  logic          dma_req = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic          dma_rw = 1'b1;
  logic [7:0]    dma_wdata = '0;
  logic          dma_grant;
  logic [AW-1:0] bus_addr;
  logic          bus_rw;
  logic [7:0]    bus_wdata;
  logic          bus_owner;
  logic          err_clear = 1'b0;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // CPU model controls
  bit            cpu_never = 1'b0;
  bit            cpu_hold = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  int            ba_delay = 2;
  int            rel_delay = 0;

  bit    mon_en = 1'b0;
  xfer_t xq[$];
  run_t  rq[$];

  logic [7:0] ram [0:65535];

  always #5 clock = ~clock;

  dma_bus_arbiter #(
    .ADDR_WIDTH   (AW),
    .MAX_BURST    (MAX_BURST),
    .CPU_SLOT     (CPU_SLOT),
    .GRANT_TIMEOUT(GRANT_TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_rw     (cpu_rw),
    .cpu_dout   (cpu_dout),
    .cpu_ba     (cpu_ba),
    .cpu_bs     (cpu_bs),
    .cpu_halt   (cpu_halt),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_rw     (dma_rw),
    .dma_wdata  (dma_wdata),
    .dma_grant  (dma_grant),
    .bus_addr   (bus_addr),
    .bus_rw     (bus_rw),
    .bus_wdata  (bus_wdata),
    .bus_owner  (bus_owner),
    .err_clear  (err_clear),
    .timeout_err(timeout_err)
  );

  // RAM on the muxed bus
  always @(posedge clock) begin
    if (!bus_rw) ram[bus_addr] <= bus_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s at %0t", name, msg, $time);
  endtask

  // CPU: BA/BS follow halt after ba_delay cycles, drop rel_delay cycles after halt falls.
  initial begin : cpu_model
    int hcnt;
    int rcnt;
    hcnt = 0;
    rcnt = 0;
    cpu_ba = 1'b0;
    cpu_bs = 1'b0;
    cpu_rw = 1'b1;
    cpu_dout = 8'h00;
    cpu_addr = 16'h1000;
    forever begin
      @(posedge clock);
      #1;
      cpu_addr = cpu_hold ? hold_addr : AW'($urandom);
      cpu_dout = 8'($urandom);
      if (cpu_halt) begin
        rcnt = 0;
        hcnt++;
        if (!cpu_never && hcnt >= ba_delay) begin
          cpu_ba = 1'b1;
          cpu_bs = 1'b1;
        end
      end else begin
        hcnt = 0;
        if (cpu_ba) begin
          if (rcnt >= rel_delay) begin
            cpu_ba = 1'b0;
            cpu_bs = 1'b0;
          end else begin
            rcnt++;
          end
        end
      end
    end
  end

  // Monitor: bus mux, transfer data, grant-run length and CPU window between bursts.
  initial begin : monitor
    int    run_len;
    bit    in_run;
    bit    gap_mode;
    int    gap_cnt;
    xfer_t ex;
    run_t  er;
    run_len = 0;
    in_run = 1'b0;
    gap_mode = 1'b0;
    gap_cnt = 0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        in_run = 1'b0;
        gap_mode = 1'b0;
      end else begin
        if (dma_grant)
          check("bus_mux_dma", 32'({bus_owner, bus_addr, bus_rw, bus_wdata}),
                32'({1'b1, dma_addr, dma_rw, dma_wdata}));
        else
          check("bus_mux_cpu", 32'({bus_owner, bus_addr, bus_rw, bus_wdata}),
                32'({1'b0, cpu_addr, cpu_rw, cpu_dout}));
        if (dma_grant && dma_req) begin
          if (xq.size() == 0) fail_now("xfer_underflow", "transfer with nothing queued");
          else begin
            ex = xq.pop_front();
            check("xfer_data", 32'({bus_addr, bus_rw, bus_wdata}), 32'(ex));
          end
        end
        if (dma_grant) begin
          if (!in_run) begin
            in_run = 1'b1;
            run_len = 0;
            gap_mode = 1'b0;
          end
          if (dma_req) run_len++;
          check("halt_in_grant", 32'(cpu_halt), 32'd1);
        end else if (in_run) begin
          in_run = 1'b0;
          check("halt_after_grant", 32'(cpu_halt), 32'd0);
          if (rq.size() == 0) fail_now("run_underflow", "grant run with nothing queued");
          else begin
            er = rq.pop_front();
            check("burst_len", run_len, er.len);
            if (er.more) begin
              gap_mode = 1'b1;
              gap_cnt = 0;
            end
          end
        end
        if (gap_mode && !dma_grant) begin
          if (cpu_halt) begin
            gap_mode = 1'b0;
            // one RELEASE cycle after BA fell, CPU_SLOT cooldown cycles, one IDLE cycle
            check("cpu_window", gap_cnt, 32'(CPU_SLOT + 2));
          end else begin
            if (!cpu_ba) gap_cnt++;
            if (gap_cnt > 1000) begin
              gap_mode = 1'b0;
              fail_now("cpu_window", "no new halt request after release");
            end
          end
        end
      end
    end
  end

  // Issue n transfers with dma_req held until all are accepted; expectations are derived
  // from the burst rule: n splits into chunks of at most MAX_BURST.
  task automatic run_burst(input int n, input int gap);
    xfer_t xf[$];
    xfer_t t;
    int    acc = 0;
    int    rem = n;
    int    chunk;
    int    guard = 0;
    run_t  r;
    for (int i = 0; i < n; i++) begin
      t.a  = AW'($urandom);
      t.rw = 1'($urandom_range(0, 1));
      t.d  = 8'($urandom);
      xf.push_back(t);
      xq.push_back(t);
    end
    while (rem > 0) begin
      chunk = (rem > int'(MAX_BURST)) ? int'(MAX_BURST) : rem;
      rem -= chunk;
      r.len = chunk;
      r.more = (rem > 0);
      rq.push_back(r);
    end
    @(posedge clock);
    #1;
    while (acc < n && guard < 2000) begin
      dma_req = 1'b1;
      {dma_addr, dma_rw, dma_wdata} = xf[acc];
      @(negedge clock);
      if (dma_grant) acc++;
      @(posedge clock);
      #1;
      guard++;
    end
    if (acc < n) check("driver_accepts", acc, n);
    dma_req = 1'b0;
    dma_rw = 1'b1;
    repeat (gap) @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for a grant; returns at a negedge.
  task automatic wait_grant(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!dma_grant && n < 64);
    if (!dma_grant) fail_now(name, "no grant within 64 cycles");
  endtask

  task automatic idle_wait();
    repeat (12) @(posedge clock);
    #1;
  endtask

  // CPU never answers; halt must be held for exactly GRANT_TIMEOUT cycles.
  task automatic timeout_run(input bit hold_clear);
    int hc = 0;
    bit gseen = 1'b0;
    int n = 0;
    cpu_never = 1'b1;
    err_clear = hold_clear;
    @(posedge clock);
    #1;
    dma_req = 1'b1;
    dma_addr = 16'h0777;
    @(posedge clock);
    #1;
    dma_req = 1'b0;
    do begin
      @(negedge clock);
      if (cpu_halt) hc++;
      if (dma_grant) gseen = 1'b1;
      n++;
    end while (cpu_halt && n < 400);
    check("timeout_halt_cycles", hc, 32'(GRANT_TIMEOUT));
    check("timeout_no_grant", 32'(gseen), 32'd0);
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    cpu_never = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_halt", 32'(cpu_halt), 32'd0);
    check("rst_grant", 32'(dma_grant), 32'd0);
    check("rst_owner", 32'(bus_owner), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_wait();

    // Single transfer
    dma_req = 1'b1;
    dma_addr = 16'h0123;
    dma_rw = 1'b1;
    dma_wdata = 8'h00;
    @(negedge clock);
    check("halt_not_yet", 32'(cpu_halt), 32'd0);
    @(negedge clock);
    check("halt_raised", 32'(cpu_halt), 32'd1);
    wait_grant("single_grant");
    check("single_addr", 32'(bus_addr), 32'h0123);
    check("single_owner", 32'(bus_owner), 32'd1);
    @(posedge clock);
    #1;
    dma_req = 1'b0;
    @(negedge clock);
    check("single_release_cycle", 32'(dma_grant), 32'd1);
    @(negedge clock);
    check("single_released", 32'(dma_grant), 32'd0);
    check("single_halt_low", 32'(cpu_halt), 32'd0);
    check("single_cpu_bus", 32'(bus_addr), 32'(cpu_addr));
    idle_wait();

    // Write path and CPU readback
    dma_req = 1'b1;
    dma_addr = 16'h0400;
    dma_rw = 1'b0;
    dma_wdata = 8'hA5;
    wait_grant("write_grant");
    check("write_rw", 32'(bus_rw), 32'd0);
    check("write_wdata", 32'(bus_wdata), 32'hA5);
    check("write_addr", 32'(bus_addr), 32'h0400);
    @(posedge clock);
    #1;
    dma_req = 1'b0;
    dma_rw = 1'b1;
    idle_wait();
    hold_addr = 16'h0400;
    cpu_hold = 1'b1;
    repeat (2) @(negedge clock);
    check("readback_addr", 32'(bus_addr), 32'h0400);
    check("ram_readback", 32'(ram[bus_addr]), 32'hA5);
    cpu_hold = 1'b0;
    idle_wait();

    // Timeout, sticky flag, synchronous clear
    timeout_run(1'b0);
    repeat (3) @(negedge clock);
    check("err_sticky", 32'(timeout_err), 32'd1);
    @(posedge clock);
    #1;
    err_clear = 1'b1;
    @(posedge clock);
    #1;
    err_clear = 1'b0;
    @(negedge clock);
    check("err_cleared", 32'(timeout_err), 32'd0);
    idle_wait();

    // Set wins over a clear held through the timeout
    timeout_run(1'b1);
    @(posedge clock);
    #1;
    err_clear = 1'b0;
    @(negedge clock);
    check("clear_after_set", 32'(timeout_err), 32'd0);
    idle_wait();

    // Leave the flag set so reset has something to clear
    timeout_run(1'b0);
    idle_wait();

    // Reset on the third grant cycle
    dma_req = 1'b1;
    dma_addr = 16'h0200;
    dma_rw = 1'b1;
    wait_grant("reset_test_grant");
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("third_grant_cycle", 32'(dma_grant), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    dma_req = 1'b0;
    @(negedge clock);
    check("rst_mid_grant", 32'(dma_grant), 32'd0);
    check("rst_mid_owner", 32'(bus_owner), 32'd0);
    check("rst_mid_halt", 32'(cpu_halt), 32'd0);
    check("rst_mid_err", 32'(timeout_err), 32'd0);
    @(negedge clock);
    check("rst_mid_idle", 32'(cpu_halt), 32'd0);
    idle_wait();

    // Scoreboard phase: early release, burst limit, then random bursts
    ba_delay = 2;
    rel_delay = 0;
    mon_en = 1'b1;
    run_burst(5, 8);
    run_burst(48, 8);
    for (int i = 0; i < 10; i++) begin
      ba_delay = $urandom_range(1, 4);
      rel_delay = $urandom_range(0, 2);
      run_burst($urandom_range(1, 40), $urandom_range(0, 6));
    end
    repeat (40) @(posedge clock);
    check("xq_drained", 32'(xq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Shares the 6809 system bus (ROM/RAM/ACIA address/data/rw) between the cpu09 core and one DMA requester, such as a serial loader or a block-copy engine.
- Uses the 6809 HALT/BA/BS handshake to take the bus from the CPU. It bounds DMA burst length and guarantees the CPU a minimum run window between bursts.
- Sits between the CPU and the address decoder. Its muxed bus outputs feed the decoder, the RAM, and the ACIA.

Parameters:
- ADDR_WIDTH, 16, width of CPU, DMA and muxed addresses
- MAX_BURST, 16, maximum DMA transfers per grant (1..255)
- CPU_SLOT, 4, minimum clock cycles the CPU owns the bus after a release (0..255)
- GRANT_TIMEOUT, 255, maximum cycles to wait for BA&BS after asserting halt (1..255)

Ports:
- clock, input, 1, system clock (E domain); all state changes on its rising edge
- reset, input, 1, synchronous, active-high reset
- cpu_addr, input, ADDR_WIDTH, CPU address
- cpu_rw, input, 1, CPU read-not-write
- cpu_dout, input, 8, CPU write data
- cpu_ba, input, 1, CPU bus-available
- cpu_bs, input, 1, CPU bus-status
- cpu_halt, output, 1, halt request to the CPU (registered)
- dma_req, input, 1, DMA wants the bus / transfer valid this cycle
- dma_addr, input, ADDR_WIDTH, DMA address
- dma_rw, input, 1, DMA read-not-write
- dma_wdata, input, 8, DMA write data
- dma_grant, output, 1, DMA owns the bus; one transfer per cycle while dma_req=1
- bus_addr, output, ADDR_WIDTH, muxed address to decoder/RAM/ROM/ACIA
- bus_rw, output, 1, muxed read-not-write
- bus_wdata, output, 8, muxed write data
- bus_owner, output, 1, 0 = CPU, 1 = DMA
- err_clear, input, 1, clears timeout_err
- timeout_err, output, 1, sticky; the CPU failed to grant within GRANT_TIMEOUT

Behaviour:
- Reset values:
  - state = IDLE
  - cpu_halt = 0, dma_grant = 0, bus_owner = 0, timeout_err = 0
  - all counters = 0
- Reset asserted in any state returns to IDLE on the next edge and drops the grant immediately, including mid-burst.
- Bus mux is combinational on bus_owner:
  - bus_owner = 1: bus_addr/bus_rw/bus_wdata = dma_addr/dma_rw/dma_wdata
  - bus_owner = 0: bus_addr/bus_rw/bus_wdata = cpu_addr/cpu_rw/cpu_dout
- bus_owner = dma_grant = (state == GRANTED).
- IDLE:
  - cpu_halt = 0.
  - dma_req = 1 → HALT_REQ, with cpu_halt = 1 from the next cycle. Load the wait counter with 0.
- HALT_REQ:
  - cpu_halt = 1; the wait counter increments each cycle.
  - cpu_ba = 1 and cpu_bs = 1 sampled → GRANTED. Burst counter = 0.
  - Otherwise, wait counter == GRANT_TIMEOUT-1 → set timeout_err, go to RELEASE.
  - dma_req dropping in HALT_REQ is ignored; the grant still completes and then releases on the first GRANTED cycle with dma_req = 0.
- GRANTED:
  - cpu_halt = 1.
  - Each cycle with dma_req = 1 is one transfer, and the burst counter increments.
  - dma_req = 0 → RELEASE. That cycle is not a transfer.
  - A transfer that makes burst count == MAX_BURST → RELEASE. dma_grant is low the following cycle.
  - The minimum grant is 1 cycle.
- RELEASE:
  - cpu_halt = 0; the bus is already back with the CPU.
  - Wait until cpu_ba = 0. Then go to COOLDOWN, or to IDLE if CPU_SLOT == 0.
- COOLDOWN:
  - cpu_halt = 0. The slot counter counts CPU_SLOT cycles and then goes to IDLE.
  - dma_req is ignored (not latched) during COOLDOWN.
  - Continuous dma_req therefore yields alternating bursts of MAX_BURST transfers and CPU windows of at least CPU_SLOT cycles.
- timeout_err:
  - Set on timeout and held until err_clear = 1 (synchronous clear).
  - Set takes priority over a simultaneous clear.
  - Does not block later requests.
- Counters are 8-bit and saturate; they never wrap within a state.

Test Plan:
- Single transfer: dma_req = 1 for 1 cycle then held until grant; CPU model answers BA = BS = 1 two cycles after halt. Required: cpu_halt high, dma_grant high for exactly the cycles dma_req stays 1, bus_addr = dma_addr (0x0123) while granted, then cpu_halt = 0 and cpu_addr back on the bus.
- Burst limit: dma_req held high, MAX_BURST = 16, CPU_SLOT = 4. Required: exactly 16 grant cycles, release, at least 4 COOLDOWN cycles after BA falls with cpu_halt = 0, then a new HALT_REQ; repeats 3 times.
- Timeout: CPU never asserts BA. Required: timeout_err = 1 after 255 HALT_REQ cycles, cpu_halt = 0, dma_grant never 1. Then err_clear = 1 → timeout_err = 0 the next cycle.
- Early release: dma_req drops after 5 transfers. Required: grant ends with burst count = 5 and the FSM enters RELEASE.
- Reset mid-burst: reset = 1 on the 3rd grant cycle. Required: the next cycle has dma_grant = 0, bus_owner = 0, cpu_halt = 0, state IDLE, timeout_err = 0.
- Write path: DMA writes 0xA5 to 0x0400 while granted. Required: bus_rw = 0, bus_wdata = 0xA5, bus_addr = 0x0400 in that cycle, and RAM readback by the CPU returns 0xA5.
